prog_load_ctrl: RTL and testbench
=================================

// Module: prog_load_ctrl
// PURPOSE
//  Hardware boot/test controller for the 16-bit RISC CPU. Accepts a program as a valid/ready word stream,
//  writes it into instruction memory from address 0, optionally checksums it by readback, then holds the
//  CPU in reset for a fixed count, runs it with PC enabled, and counts cycles until HLT or timeout.
//  Sits between the external test port and the CPU's instruction-memory load path and clr_n/PC_en inputs.
// PARAMETERS
//  DATA_W          16   instruction word width
//  ADDR_W          8    instruction-memory address width; depth = 2**ADDR_W
//  CPU_RST_CYCLES  9    cycles cpu_clr_n is held low before run (>=1)
//  CNT_W           16   run-cycle counter width
// PORTS
//  CLK          in   1         clock, all state on rising edge
//  clr          in   1         asynchronous, active-high reset
//  start        in   1         pulse: begin load (IDLE) or restart (DONE/ERROR)
//  abort        in   1         synchronous return to IDLE from any state
//  prog_len     in   ADDR_W+1  number of words to load, sampled on accepted start
//  s_valid      in   1         stream word valid
//  s_data       in   DATA_W    stream word
//  s_ready      out  1         controller accepts word this cycle
//  imem_we      out  1         instruction-memory write strobe
//  imem_addr    out  ADDR_W    instruction-memory address (write and readback)
//  imem_wdata   out  DATA_W    instruction-memory write data
//  imem_rdata   in   DATA_W    readback data, valid 1 cycle after imem_addr (sync RAM)
//  cpu_clr_n    out  1         CPU reset, active low
//  pc_en        out  1         CPU PC enable
//  cpu_hlt      in   1         CPU HLT flag
//  busy         out  1         state not IDLE/DONE/ERROR
//  done         out  1         run ended by HLT; level, held in DONE
//  error        out  1         level, held in ERROR
//  err_code     out  2         0 none, 1 bad length, 2 checksum mismatch, 3 run timeout
//  cycle_count  out  CNT_W     cycles spent in RUN; frozen in DONE/ERROR
// BEHAVIOUR
//  Reset (clr high, async): state IDLE; all outputs 0 (cpu_clr_n=0, pc_en=0, cycle_count=0).
//  States: IDLE -> LOAD -> [VERIFY] -> CPU_RST -> RUN -> DONE | ERROR.
//  IDLE: s_ready=0, cpu_clr_n=0. On start: prog_len==0 or > 2**ADDR_W -> ERROR code 1; else LOAD,
//   wr_addr=0, checksum=0, cycle_count=0, err_code=0.
//  LOAD: s_ready=1. Accept = s_valid&s_ready; imem_we=accept (combinational), imem_addr=wr_addr,
//   imem_wdata=s_data; checksum += s_data mod 2**DATA_W. Accept at wr_addr==prog_len-1 -> next state
//   (VERIFY if enabled else CPU_RST); wr_addr never wraps. s_valid low: stall, no write.
//  VERIFY: s_ready=0, imem_we=0; sweep imem_addr 0..prog_len-1 one per cycle, accumulate imem_rdata with
//   1-cycle lag (prog_len+1 cycles). Sum != checksum -> ERROR code 2; equal -> CPU_RST.
//  CPU_RST: cpu_clr_n=0, pc_en=1 for exactly CPU_RST_CYCLES cycles, then RUN. cpu_hlt ignored here.
//  RUN: cpu_clr_n=1, pc_en=1, cycle_count+1 per cycle. cpu_hlt high -> DONE (that cycle not counted).
//   cycle_count reaching all-ones without HLT -> ERROR code 3. HLT and saturation same cycle -> DONE.
//  DONE/ERROR: cpu_clr_n=0, pc_en=0, done/error held. start -> restart as from IDLE (prog_len resampled).
//  start while busy: ignored. abort: IDLE next cycle, done/error/err_code cleared, cpu_clr_n=0;
//   abort wins over start and cpu_hlt in same cycle. Stream word presented during abort not accepted.
// CONFIGURATION
//  VERIFY_READBACK_EN defined: VERIFY state present, checksum compared, err_code 2 reachable.
//  Undefined: LOAD goes straight to CPU_RST; checksum logic removed; err_code 2 never produced.
// TESTING
//  1 Load 8 words (mov-block program, HLT at 7), s_valid always high -> 8 imem_we pulses addr 0..7,
//    cpu_clr_n low 9 cycles, RUN, done=1, cycle_count = CPU's run cycles to HLT, err_code=0.
//  2 Same load, s_valid toggled 1/0 -> writes only on valid cycles, same memory image, same result.
//  3 VERIFY_READBACK_EN, bench RAM corrupts addr 3 on readback -> error=1, err_code=2, cpu never released.
//  4 prog_len=0 and prog_len=257 (ADDR_W=8) -> ERROR code 1 next cycle, no imem_we.
//  5 CNT_W=4, program without HLT -> ERROR code 3 after 15 RUN cycles, cycle_count=15, pc_en drops.
//  6 abort mid-LOAD after 3 words, and clr asserted mid-RUN -> IDLE, cpu_clr_n=0, outputs at reset values.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: streams a program into instruction memory, then boots and times the CPU.
// Optional readback checksum stage is enabled by defining VERIFY_READBACK_EN.
module prog_load_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int CPU_RST_CYCLES = 9,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              cpu_clr_n,
  output logic              pc_en,
  input  logic              cpu_hlt,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_CPU_RST,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int RW = $clog2(CPU_RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST =
    RW'(CPU_RST_CYCLES - 1);
  localparam logic [ADDR_W:0] LEN_MAX =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t             state;
  logic [ADDR_W:0]    len_q;
  logic [ADDR_W-1:0]  wr_addr;
  logic [RW-1:0]      rst_cnt;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               last_wr;
  logic               len_bad;
  logic [CNT_W-1:0]   cnt_inc;

`ifdef VERIFY_READBACK_EN
  logic [DATA_W-1:0]  csum;
  logic [DATA_W-1:0]  vsum;
  logic [DATA_W-1:0]  vsum_fin;
  logic [ADDR_W:0]    vcnt;
  logic               v_last;

  // readback data lags the address by one cycle, so slot 0 carries nothing
  assign vsum_fin = vsum + ((vcnt != '0) ? imem_rdata : '0);
  assign v_last   = (vcnt == len_q);
`else
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata;
`endif

  assign s_ready = (state == S_LOAD) && !abort;
  assign accept  = s_valid && s_ready;
  assign imem_we = accept;
  assign imem_wdata = (state == S_LOAD) ? s_data : '0;
  assign last_wr = ({1'b0, wr_addr} == (len_q - 1'b1));
  assign len_bad = (prog_len == '0) || (prog_len > LEN_MAX);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    imem_addr = '0;
    if (state == S_LOAD) begin
      imem_addr = wr_addr;
    end
`ifdef VERIFY_READBACK_EN
    else if (state == S_VERIFY) begin
      imem_addr = vcnt[ADDR_W-1:0];
    end
`endif
  end

  assign cpu_clr_n   = (state == S_RUN);
  assign pc_en       = (state == S_RUN) ||
                       (state == S_CPU_RST);
  assign busy        = (state != S_IDLE) &&
                       (state != S_DONE) &&
                       (state != S_ERROR);
  assign done        = (state == S_DONE);
  assign error       = (state == S_ERROR);
  assign err_code    = err_q;
  assign cycle_count = cnt_q;

  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      state   <= S_IDLE;
      len_q   <= '0;
      wr_addr <= '0;
      rst_cnt <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
`ifdef VERIFY_READBACK_EN
      csum    <= '0;
      vsum    <= '0;
      vcnt    <= '0;
`endif
    end else if (abort) begin
      state <= S_IDLE;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            len_q   <= prog_len;
            wr_addr <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
`ifdef VERIFY_READBACK_EN
            csum    <= '0;
`endif
            if (len_bad) begin
              state <= S_ERROR;
              err_q <= 2'd1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
`ifdef VERIFY_READBACK_EN
            csum <= csum + s_data;
`endif
            if (last_wr) begin
              rst_cnt <= '0;
`ifdef VERIFY_READBACK_EN
              vsum  <= '0;
              vcnt  <= '0;
              state <= S_VERIFY;
`else
              state <= S_CPU_RST;
`endif
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
`ifdef VERIFY_READBACK_EN
        S_VERIFY: begin
          if (v_last) begin
            if (vsum_fin != csum) begin
              state <= S_ERROR;
              err_q <= 2'd2;
            end else begin
              rst_cnt <= '0;
              state   <= S_CPU_RST;
            end
          end else begin
            vsum <= vsum_fin;
            vcnt <= vcnt + 1'b1;
          end
        end
`endif
        S_CPU_RST: begin
          if (rst_cnt == RST_LAST) begin
            state <= S_RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // HLT takes priority over a saturating count in the same cycle
          if (cpu_hlt) begin
            state <= S_DONE;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_SAT) begin
              state <= S_ERROR;
              err_q <= 2'd3;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed bench with a behavioural sync RAM and toy CPU.
// Uses CNT_W=4 so the run-timeout path is reachable in a few cycles.
module tb_prog_load_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam logic [DW-1:0] HLT = 16'hF000;

  logic          CLK = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [DW-1:0] imem_rdata;
  logic          cpu_clr_n;
  logic          pc_en;
  logic          cpu_hlt;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [CW-1:0] cycle_count;

  logic          corrupt = 1'b0;
  int            vecs = 0;
  int            errs = 0;

  prog_load_ctrl #(
    .DATA_W(DW), .ADDR_W(AW),
    .CPU_RST_CYCLES(9), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .clr(clr), .start(start),
    .abort(abort), .prog_len(prog_len),
    .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata),
    .cpu_clr_n(cpu_clr_n), .pc_en(pc_en),
    .cpu_hlt(cpu_hlt), .busy(busy),
    .done(done), .error(error),
    .err_code(err_code),
    .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [0:255] = '{default: '0};
  logic [AW-1:0] log_addr [0:1023];
  logic [DW-1:0] log_data [0:1023];
  int wr_total = 0;
  int rst_total = 0;
  int run_total = 0;
  logic [7:0] pc = '0;

  always @(posedge CLK) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      if (wr_total < 1024) begin
        log_addr[wr_total] <= imem_addr;
        log_data[wr_total] <= imem_wdata;
      end
      wr_total <= wr_total + 1;
    end
    if (pc_en && !cpu_clr_n) rst_total <= rst_total + 1;
    if (cpu_clr_n) run_total <= run_total + 1;
    imem_rdata <= mem[imem_addr] ^
      ((corrupt && imem_addr == 8'd3) ? 16'h0001 : 16'h0000);
  end

  // toy CPU: PC walks memory from 0 until it fetches HLT
  always @(posedge CLK) begin
    if (!cpu_clr_n) pc <= '0;
    else if (pc_en && !cpu_hlt) pc <= pc + 8'd1;
  end
  assign cpu_hlt = cpu_clr_n && (mem[pc] == HLT);

  function automatic logic [DW-1:0] word(input int i, input bit hlt);
    if (hlt && i == 7) return HLT;
    return 16'h1000 | 16'(i);
  endfunction

  task automatic run_prog(input bit hlt, input bit toggle);
    int i;
    int g;
    bit acc;
    @(negedge CLK);
    prog_len = 9'd8;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    i = 0;
    g = 0;
    while (i < 8 && g < 64) begin
      s_valid = toggle ? (g[0] == 1'b0) : 1'b1;
      s_data = word(i, hlt);
      acc = s_valid && s_ready;
      @(negedge CLK);
      if (acc) i++;
      g++;
    end
    s_valid = 1'b0;
    s_data = '0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done || error) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL wait_end: done=%b error=%b after 300 cycles, want one set",
               done, error);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    vecs++;
    if ({s_ready, imem_we, cpu_clr_n, pc_en, busy, done, error} !== 7'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b want 0000000",
               {s_ready, imem_we, cpu_clr_n, pc_en, busy, done, error});
    end
    vecs++;
    if (err_code !== 2'd0 || cycle_count !== 4'd0) begin
      errs++;
      $display("FAIL reset_regs: err_code=%0d count=%0d want 0 0", err_code, cycle_count);
    end
    clr = 1'b0;
  endtask

  task automatic test_load_run(input bit toggle);
    int w0, r0, u0;
    bit ok;
    w0 = wr_total;
    r0 = rst_total;
    u0 = run_total;
    run_prog(1'b1, toggle);
    wait_end(ok);
    vecs++;
    if (wr_total - w0 !== 8) begin
      errs++;
      $display("FAIL load_writes t=%0b: got %0d want 8", toggle, wr_total - w0);
    end
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if (log_addr[w0+k] !== AW'(k) || log_data[w0+k] !== word(k, 1'b1)) begin
        errs++;
        $display("FAIL load_word%0d t=%0b: got @%0d=%h want @%0d=%h", k, toggle,
                 log_addr[w0+k], log_data[w0+k], k, word(k, 1'b1));
      end
    end
    vecs++;
    if (rst_total - r0 !== 9) begin
      errs++;
      $display("FAIL cpu_rst_len t=%0b: got %0d want 9", toggle, rst_total - r0);
    end
    vecs++;
    if (run_total - u0 !== 8) begin
      errs++;
      $display("FAIL run_len t=%0b: got %0d want 8", toggle, run_total - u0);
    end
    vecs++;
    if (!(done === 1'b1 && error === 1'b0 && err_code === 2'd0)) begin
      errs++;
      $display("FAIL run_status t=%0b: done=%b error=%b code=%0d want 1 0 0",
               toggle, done, error, err_code);
    end
    vecs++;
    if (cycle_count !== 4'd7) begin
      errs++;
      $display("FAIL run_count t=%0b: got %0d want 7", toggle, cycle_count);
    end
    vecs++;
    if ({cpu_clr_n, pc_en, busy} !== 3'b000) begin
      errs++;
      $display("FAIL done_outs t=%0b: got %b want 000", toggle, {cpu_clr_n, pc_en, busy});
    end
  endtask

  task automatic test_bad_len;
    int w0;
    logic [AW:0] lens [2];
    lens[0] = 9'd0;
    lens[1] = 9'd257;
    w0 = wr_total;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      prog_len = lens[k];
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      vecs++;
      if (!(error === 1'b1 && err_code === 2'd1 && busy === 1'b0 && cpu_clr_n === 1'b0)) begin
        errs++;
        $display("FAIL bad_len%0d: error=%b code=%0d busy=%b clr_n=%b want 1 1 0 0",
                 lens[k], error, err_code, busy, cpu_clr_n);
      end
    end
    vecs++;
    if (wr_total !== w0) begin
      errs++;
      $display("FAIL bad_len_writes: got %0d want 0", wr_total - w0);
    end
    prog_len = 9'd256;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    vecs++;
    if (!(busy === 1'b1 && error === 1'b0 && s_ready === 1'b1)) begin
      errs++;
      $display("FAIL len_256: busy=%b error=%b ready=%b want 1 0 1", busy, error, s_ready);
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
  endtask

  task automatic test_timeout;
    int u0;
    bit ok;
    u0 = run_total;
    run_prog(1'b0, 1'b0);
    wait_end(ok);
    vecs++;
    if (!(error === 1'b1 && done === 1'b0 && err_code === 2'd3)) begin
      errs++;
      $display("FAIL timeout_status: error=%b done=%b code=%0d want 1 0 3",
               error, done, err_code);
    end
    vecs++;
    if (cycle_count !== 4'd15 || run_total - u0 !== 15) begin
      errs++;
      $display("FAIL timeout_count: count=%0d run=%0d want 15 15",
               cycle_count, run_total - u0);
    end
    vecs++;
    if (pc_en !== 1'b0 || cpu_clr_n !== 1'b0) begin
      errs++;
      $display("FAIL timeout_cpu: pc_en=%b clr_n=%b want 0 0", pc_en, cpu_clr_n);
    end
  endtask

`ifdef VERIFY_READBACK_EN
  task automatic test_verify_corrupt;
    int r0, u0;
    bit ok;
    r0 = rst_total;
    u0 = run_total;
    corrupt = 1'b1;
    run_prog(1'b1, 1'b0);
    wait_end(ok);
    corrupt = 1'b0;
    vecs++;
    if (!(error === 1'b1 && err_code === 2'd2)) begin
      errs++;
      $display("FAIL verify_status: error=%b code=%0d want 1 2", error, err_code);
    end
    vecs++;
    if (rst_total !== r0 || run_total !== u0) begin
      errs++;
      $display("FAIL verify_cpu: rst=%0d run=%0d want 0 0",
               rst_total - r0, run_total - u0);
    end
  endtask
`endif

  task automatic test_abort;
    int w0;
    w0 = wr_total;
    @(negedge CLK);
    prog_len = 9'd8;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = word(k, 1'b0);
      @(negedge CLK);
    end
    s_data = 16'hBEEF;
    abort = 1'b1;
    #1;
    vecs++;
    if (s_ready !== 1'b0 || imem_we !== 1'b0) begin
      errs++;
      $display("FAIL abort_accept: ready=%b we=%b want 0 0", s_ready, imem_we);
    end
    @(negedge CLK);
    abort = 1'b0;
    s_valid = 1'b0;
    vecs++;
    if ({busy, done, error, s_ready, cpu_clr_n, pc_en} !== 6'b0 || err_code !== 2'd0) begin
      errs++;
      $display("FAIL abort_idle: flags=%b code=%0d want 000000 0",
               {busy, done, error, s_ready, cpu_clr_n, pc_en}, err_code);
    end
    vecs++;
    if (wr_total - w0 !== 3) begin
      errs++;
      $display("FAIL abort_writes: got %0d want 3", wr_total - w0);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    vecs++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errs++;
      $display("FAIL abort_vs_start: busy=%b ready=%b want 0 0", busy, s_ready);
    end
  endtask

  task automatic test_clr_mid_run;
    bit seen;
    seen = 1'b0;
    run_prog(1'b0, 1'b0);
    for (int k = 0; k < 100 && !seen; k++) begin
      if (cpu_clr_n) seen = 1'b1;
      else @(negedge CLK);
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL clr_reach_run: cpu_clr_n=%b want 1 within 100 cycles", cpu_clr_n);
    end
    @(negedge CLK);
    @(negedge CLK);
    clr = 1'b1;
    #1;
    vecs++;
    if ({busy, done, error, s_ready, cpu_clr_n, pc_en} !== 6'b0 ||
        err_code !== 2'd0 || cycle_count !== 4'd0) begin
      errs++;
      $display("FAIL clr_mid_run: flags=%b code=%0d count=%0d want 000000 0 0",
               {busy, done, error, s_ready, cpu_clr_n, pc_en}, err_code, cycle_count);
    end
    @(negedge CLK);
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_run(1'b0);
    test_load_run(1'b1);
    test_bad_len();
    test_timeout();
`ifdef VERIFY_READBACK_EN
    test_verify_corrupt();
`endif
    test_abort();
    test_clr_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
